csr_dma_slave: RTL and testbench

- Parametrised successor to the PCIe-facing custom slave: an Avalon-MM CSR slave with a single-channel word-copy engine on an Avalon-MM master.
- Host software (via PCIe IP) fills a data buffer held in CSRs, programs base address, length and direction, then starts the engine.
- The engine writes the buffer to SDRAM, or reads SDRAM back into the buffer.
- It reports busy/done/error and a transferred-word count, and keeps legacy START/STOP magic-word triggering.

---
 rtl/csr_dma_slave.sv | 230 +++++++++++++++++++++++
 tb/tb_csr_dma_slave.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_dma_slave.sv
// csr_dma_slave: Avalon-MM CSR slave with a single-channel word-copy engine.
// The engine moves a CSR-held buffer to SDRAM, or reads SDRAM back into it.
module csr_dma_slave #(
    parameter int unsigned MASTER_ADDRESSWIDTH = 26,
    parameter int unsigned SLAVE_ADDRESSWIDTH  = 4,
    parameter int unsigned DATAWIDTH           = 32,
    parameter int unsigned NUMREGS             = 16,
    parameter int unsigned TIMEOUT_CYCLES      = 1024,
    parameter logic [31:0] DEFAULT_BASE        = 32'h08000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
    input  logic [DATAWIDTH-1:0]           slave_writedata,
    input  logic                           slave_write,
    input  logic                           slave_read,
    input  logic                           slave_chipselect,
    output logic [DATAWIDTH-1:0]           slave_readdata,
    output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
    output logic [DATAWIDTH-1:0]           master_writedata,
    output logic                           master_write,
    output logic                           master_read,
    input  logic [DATAWIDTH-1:0]           master_readdata,
    input  logic                           master_readdatavalid,
    input  logic                           master_waitrequest,
    output logic                           irq
);
    localparam int unsigned MAW  = MASTER_ADDRESSWIDTH;
    localparam int unsigned SAW  = SLAVE_ADDRESSWIDTH;
    localparam int unsigned DW   = DATAWIDTH;
    localparam int unsigned NBUF = NUMREGS - 4;
    localparam int unsigned IW   = $clog2(NBUF + 1);
    localparam int unsigned BW   = (NBUF > 1) ? $clog2(NBUF) : 1;
    localparam int unsigned TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [DW-1:0] MagicWr = DW'(32'hF00BF00B);
    localparam logic [DW-1:0] MagicRd = DW'(32'hDEADF00B);

    typedef enum logic [2:0] {StIdle, StWrReq, StRdReq, StRdWait, StFinish} state_e;

    state_e          state_q, state_d;
    logic            ctrl_dir_q, ctrl_dir_d;
    logic            ctrl_irq_en_q, ctrl_irq_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tmo_flag_q, tmo_flag_d;
    logic            xfer_dir_q, xfer_dir_d;
    logic [MAW-1:0]  base_q, base_d;
    logic [DW-1:0]   length_q, length_d;
    logic [DW-1:0]   buf_q [NBUF];
    logic [DW-1:0]   buf_d [NBUF];
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [DW-1:0]   readdata_q, readdata_d;

    logic            wr_en, rd_en, addr_ok, go, go_dir;
    logic [BW-1:0]   slv_buf_idx, eng_buf_idx;
    logic [IW-1:0]   eff_len, idx_inc;
    logic [DW-1:0]   rd_word;

    assign wr_en          = slave_chipselect & slave_write;
    assign rd_en          = slave_chipselect & slave_read & ~slave_write;
    assign addr_ok        = 32'(slave_address) < NUMREGS;
    assign slv_buf_idx    = BW'(slave_address - SAW'(4));
    assign eng_buf_idx    = BW'(idx_q);
    assign idx_inc        = idx_q + IW'(1);
    assign eff_len        = (length_q > DW'(NBUF)) ? IW'(NBUF) : IW'(length_q);
    assign slave_readdata = readdata_q;
    assign irq            = done_q & ctrl_irq_en_q;

    always_comb begin
        state_d          = state_q;
        ctrl_dir_d       = ctrl_dir_q;
        ctrl_irq_en_d    = ctrl_irq_en_q;
        busy_d           = busy_q;
        done_d           = done_q;
        tmo_flag_d       = tmo_flag_q;
        xfer_dir_d       = xfer_dir_q;
        base_d           = base_q;
        length_d         = length_q;
        buf_d            = buf_q;
        idx_d            = idx_q;
        tmo_cnt_d        = tmo_cnt_q;
        readdata_d       = readdata_q;
        master_address   = '0;
        master_writedata = '0;
        master_write     = 1'b0;
        master_read      = 1'b0;
        go               = 1'b0;
        go_dir           = 1'b0;
        rd_word          = '0;

        if (addr_ok) begin
            case (slave_address)
                SAW'(0): begin
                    rd_word[1] = ctrl_dir_q;
                    rd_word[2] = ctrl_irq_en_q;
                end
                SAW'(1): begin
                    rd_word[2:0]   = {tmo_flag_q, done_q, busy_q};
                    rd_word[31:16] = 16'(idx_q);
                end
                SAW'(2): rd_word = DW'(base_q);
                SAW'(3): rd_word = length_q;
                default: rd_word = buf_q[slv_buf_idx];
            endcase
        end
        if (rd_en) begin
            readdata_d = rd_word;
        end

        // DONE-clear is the only CSR write honoured while the engine is busy.
        if (wr_en && addr_ok) begin
            if (slave_address == SAW'(1)) begin
                if (slave_writedata[1]) begin
                    done_d     = 1'b0;
                    tmo_flag_d = 1'b0;
                end
            end else if (!busy_q) begin
                case (slave_address)
                    SAW'(0): begin
                        if (slave_writedata == MagicWr) begin
                            go = 1'b1;
                        end else if (slave_writedata == MagicRd) begin
                            go     = 1'b1;
                            go_dir = 1'b1;
                        end else begin
                            ctrl_dir_d    = slave_writedata[1];
                            ctrl_irq_en_d = slave_writedata[2];
                            go            = slave_writedata[0];
                            go_dir        = slave_writedata[1];
                        end
                    end
                    SAW'(2): base_d   = MAW'(slave_writedata) & ~MAW'(3);
                    SAW'(3): length_d = slave_writedata;
                    default: buf_d[slv_buf_idx] = slave_writedata;
                endcase
            end
        end

        case (state_q)
            StIdle: begin
                if (go) begin
                    xfer_dir_d = go_dir;
                    idx_d      = '0;
                    done_d     = 1'b0;
                    tmo_flag_d = 1'b0;
                    busy_d     = 1'b1;
                    if (eff_len == '0) begin
                        state_d = StFinish;
                    end else begin
                        state_d = go_dir ? StRdReq : StWrReq;
                    end
                end
            end
            StWrReq: begin
                master_write     = 1'b1;
                master_address   = base_q + (MAW'(idx_q) << 2);
                master_writedata = buf_q[eng_buf_idx];
                if (!master_waitrequest) begin
                    idx_d = idx_inc;
                    if (idx_inc == eff_len) begin
                        state_d = StFinish;
                    end
                end
            end
            StRdReq: begin
                master_read    = 1'b1;
                master_address = base_q + (MAW'(idx_q) << 2);
                if (!master_waitrequest) begin
                    tmo_cnt_d = '0;
                    state_d   = StRdWait;
                end
            end
            StRdWait: begin
                if (master_readdatavalid) begin
                    buf_d[eng_buf_idx] = master_readdata;
                    idx_d              = idx_inc;
                    state_d            = (idx_inc == eff_len) ? StFinish : StRdReq;
                end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_flag_d = 1'b1;
                    state_d    = StFinish;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            StFinish: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            ctrl_dir_q    <= 1'b0;
            ctrl_irq_en_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tmo_flag_q    <= 1'b0;
            xfer_dir_q    <= 1'b0;
            base_q        <= MAW'(DEFAULT_BASE);
            length_q      <= '0;
            for (int k = 0; k < NBUF; k++) begin
                buf_q[k] <= '0;
            end
            idx_q         <= '0;
            tmo_cnt_q     <= '0;
            readdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            ctrl_dir_q    <= ctrl_dir_d;
            ctrl_irq_en_q <= ctrl_irq_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            tmo_flag_q    <= tmo_flag_d;
            xfer_dir_q    <= xfer_dir_d;
            base_q        <= base_d;
            length_q      <= length_d;
            buf_q         <= buf_d;
            idx_q         <= idx_d;
            tmo_cnt_q     <= tmo_cnt_d;
            readdata_q    <= readdata_d;
        end
    end

endmodule

// File: tb/tb_csr_dma_slave.sv
// tb_csr_dma_slave: directed test of csr_dma_slave with a small Avalon-MM memory model.
// Expected values are hand-computed constants.
module tb_csr_dma_slave;
    localparam int unsigned MAW = 28;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [3:0]      slave_address = '0;
    logic [31:0]     slave_writedata = '0;
    logic            slave_write = 1'b0;
    logic            slave_read = 1'b0;
    logic            slave_chipselect = 1'b0;
    logic [31:0]     slave_readdata;
    logic [MAW-1:0]  master_address;
    logic [31:0]     master_writedata;
    logic            master_write;
    logic            master_read;
    logic [31:0]     mem_rdata = '0;
    logic            mem_rvalid = 1'b0;
    logic            master_waitrequest;
    logic            irq;

    int              n_checks = 0;
    int              n_fail = 0;

    logic [MAW-1:0]  wr_addr [128];
    logic [31:0]     wr_data [128];
    int              wr_n = 0;
    int              rd_n = 0;
    int              stall_cnt = 0;
    logic [MAW-1:0]  stall_addr = 28'h8000008;
    logic            resp_en = 1'b1;
    logic [31:0]     tb_base = 32'h08000000;
    int              lat = 0;
    logic [31:0]     pend = '0;

    csr_dma_slave #(
        .MASTER_ADDRESSWIDTH (MAW),
        .SLAVE_ADDRESSWIDTH  (4),
        .DATAWIDTH           (32),
        .NUMREGS             (16),
        .TIMEOUT_CYCLES      (8),
        .DEFAULT_BASE        (32'h08000000)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .slave_address        (slave_address),
        .slave_writedata      (slave_writedata),
        .slave_write          (slave_write),
        .slave_read           (slave_read),
        .slave_chipselect     (slave_chipselect),
        .slave_readdata       (slave_readdata),
        .master_address       (master_address),
        .master_writedata     (master_writedata),
        .master_write         (master_write),
        .master_read          (master_read),
        .master_readdata      (mem_rdata),
        .master_readdatavalid (mem_rvalid),
        .master_waitrequest   (master_waitrequest),
        .irq                  (irq)
    );

    always #5 clk = ~clk;

    // Two stall cycles on the first write that hits stall_addr.
    assign master_waitrequest = master_write && (master_address == stall_addr) && (stall_cnt < 2);

    always @(posedge clk) begin
        if (master_waitrequest) stall_cnt <= stall_cnt + 1;
        mem_rvalid <= 1'b0;
        if (lat != 0) begin
            lat <= lat - 1;
            if (lat == 1) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= pend;
            end
        end
        if (master_read && !master_waitrequest && resp_en) begin
            lat  <= 3;
            pend <= 32'hA0 + ((32'(master_address) - tb_base) >> 2);
        end
    end

    always @(negedge clk) begin
        if (!reset && master_write && !master_waitrequest) begin
            if (wr_n < 128) begin
                wr_addr[wr_n] = master_address;
                wr_data[wr_n] = master_writedata;
            end
            wr_n++;
        end
        if (!reset && master_read && !master_waitrequest) rd_n++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_chipselect = 1'b1;
        slave_write      = 1'b1;
        slave_address    = a;
        slave_writedata  = d;
        @(negedge clk);
        slave_chipselect = 1'b0;
        slave_write      = 1'b0;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        slave_chipselect = 1'b1;
        slave_read       = 1'b1;
        slave_address    = a;
        @(negedge clk);
        slave_chipselect = 1'b0;
        slave_read       = 1'b0;
        d = slave_readdata;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] v;
        csr_read(a, v);
        check_val(tag, v, exp);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] st;
        st = 32'h1;
        for (int k = 0; k < 100 && st[0]; k++) csr_read(4'd1, st);
        check_val(tag, {31'b0, st[0]}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, r0;
        logic [31:0] v1, v2;
        logic found;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_val("rst_readdata", slave_readdata, 32'h0);
        check_val("rst_mwrite", {30'b0, master_write, master_read}, 32'h0);
        check_val("rst_irq", {31'b0, irq}, 32'h0);
        check_reg("rst_base", 4'd2, 32'h08000000);
        check_reg("rst_ctrl", 4'd0, 32'h0);

        // Simultaneous read+write: write happens, readdata holds.
        @(negedge clk);
        slave_chipselect = 1'b1; slave_write = 1'b1; slave_read = 1'b1;
        slave_address = 4'd3; slave_writedata = 32'd5;
        @(negedge clk);
        slave_chipselect = 1'b0; slave_write = 1'b0; slave_read = 1'b0;
        check_val("rw_hold", slave_readdata, 32'h0);
        check_reg("rw_len", 4'd3, 32'd5);

        // Buffer -> SDRAM with a stall on word 2.
        for (int k = 0; k < 4; k++) csr_write(4'(4 + k), 32'(k + 1));
        csr_write(4'd2, 32'h08000003);
        check_reg("base_align", 4'd2, 32'h08000000);
        csr_write(4'd3, 32'd4);
        w0 = wr_n;
        csr_write(4'd0, 32'h1);
        wait_idle("t1_idle");
        check_val("t1_nwr", 32'(wr_n - w0), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("t1_addr%0d", k), 32'(wr_addr[w0 + k]), 32'h08000000 + 32'(4 * k));
            check_val($sformatf("t1_data%0d", k), wr_data[w0 + k], 32'(k + 1));
        end
        check_reg("t1_status", 4'd1, 32'h00040002);
        check_val("idle_addr", 32'(master_address), 32'h0);
        check_val("idle_wdata", master_writedata, 32'h0);

        // SDRAM -> buffer.
        csr_write(4'd3, 32'd3);
        r0 = rd_n;
        csr_write(4'd0, 32'h3);
        wait_idle("t2_idle");
        check_val("t2_nrd", 32'(rd_n - r0), 32'd3);
        check_reg("t2_buf4", 4'd4, 32'hA0);
        check_reg("t2_buf5", 4'd5, 32'hA1);
        check_reg("t2_buf6", 4'd6, 32'hA2);
        check_reg("t2_buf7", 4'd7, 32'h4);
        check_reg("t2_status", 4'd1, 32'h00030002);
        check_val("t2_irq", {31'b0, irq}, 32'h0);
        check_reg("t2_ctrl", 4'd0, 32'h2);
        csr_write(4'd0, 32'h4);
        check_val("t2_irq_en", {31'b0, irq}, 32'h1);
        csr_write(4'd1, 32'h2);
        check_val("t2_irq_clr", {31'b0, irq}, 32'h0);
        check_reg("t2_status_clr", 4'd1, 32'h00030000);
        csr_write(4'd0, 32'h0);

        // Legacy write trigger, length clamped to NBUF.
        for (int k = 0; k < 12; k++) csr_write(4'(4 + k), 32'h100 + 32'(k));
        csr_write(4'd3, 32'd20);
        w0 = wr_n;
        csr_write(4'd0, 32'hF00BF00B);
        wait_idle("t3_idle");
        check_val("t3_nwr", 32'(wr_n - w0), 32'd12);
        check_val("t3_first_data", wr_data[w0], 32'h100);
        check_val("t3_last_addr", 32'(wr_addr[w0 + 11]), 32'h0800002C);
        check_val("t3_last_data", wr_data[w0 + 11], 32'h10B);
        check_reg("t3_status", 4'd1, 32'h000C0002);
        check_reg("t3_ctrl", 4'd0, 32'h0);
        check_reg("t3_len", 4'd3, 32'd20);

        // Legacy read trigger with no response -> timeout.
        csr_write(4'd3, 32'd2);
        resp_en = 1'b0;
        r0 = rd_n;
        csr_write(4'd0, 32'hDEADF00B);
        wait_idle("t4_idle");
        check_val("t4_nrd", 32'(rd_n - r0), 32'd1);
        check_reg("t4_status", 4'd1, 32'h00000006);
        check_reg("t4_ctrl", 4'd0, 32'h0);
        csr_write(4'd1, 32'h2);
        check_reg("t4_status_clr", 4'd1, 32'h0);
        resp_en = 1'b1;

        // CSR writes and GO while busy are ignored.
        csr_write(4'd3, 32'd12);
        w0 = wr_n;
        csr_write(4'd0, 32'h1);
        csr_write(4'd2, 32'h100);
        csr_write(4'd4, 32'hFFFF);
        csr_write(4'd0, 32'h1);
        wait_idle("t5_idle");
        repeat (30) @(negedge clk);
        check_val("t5_nwr", 32'(wr_n - w0), 32'd12);
        check_val("t5_first_addr", 32'(wr_addr[w0]), 32'h08000000);
        check_val("t5_last_addr", 32'(wr_addr[w0 + 11]), 32'h0800002C);
        check_val("t5_first_data", wr_data[w0], 32'h100);
        check_reg("t5_base", 4'd2, 32'h08000000);
        check_reg("t5_buf4", 4'd4, 32'h100);

        // Address wrap at the top of the master space.
        csr_write(4'd2, 32'h0FFFFFFF);
        check_reg("t6_base", 4'd2, 32'h0FFFFFFC);
        csr_write(4'd3, 32'd2);
        w0 = wr_n;
        csr_write(4'd0, 32'h1);
        wait_idle("t6_idle");
        check_val("t6_nwr", 32'(wr_n - w0), 32'd2);
        check_val("t6_addr0", 32'(wr_addr[w0]), 32'h0FFFFFFC);
        check_val("t6_addr1", 32'(wr_addr[w0 + 1]), 32'h0);
        check_val("t6_data1", wr_data[w0 + 1], 32'h101);

        // Reset during the 5th accepted word.
        csr_write(4'd2, 32'h08000000);
        csr_write(4'd3, 32'd12);
        csr_write(4'd0, 32'h1);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (master_write && !master_waitrequest && master_address == 28'h8000010) found = 1'b1;
        end
        check_val("t7_hit", {31'b0, found}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("t7_bus_off", {30'b0, master_write, master_read}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check_reg("t7_ctrl", 4'd0, 32'h0);
        check_reg("t7_status", 4'd1, 32'h0);
        check_reg("t7_base", 4'd2, 32'h08000000);
        check_reg("t7_len", 4'd3, 32'h0);
        check_reg("t7_buf4", 4'd4, 32'h0);
        check_reg("t7_buf15", 4'd15, 32'h0);

        // Zero-length GO: no bus traffic, DONE two cycles after GO.
        w0 = wr_n;
        r0 = rd_n;
        csr_write(4'd0, 32'h1);
        slave_chipselect = 1'b1; slave_read = 1'b1; slave_address = 4'd1;
        @(negedge clk);
        v1 = slave_readdata;
        @(negedge clk);
        v2 = slave_readdata;
        slave_chipselect = 1'b0; slave_read = 1'b0;
        check_val("t8_status_n1", v1, 32'h00000001);
        check_val("t8_status_n2", v2, 32'h00000002);
        repeat (5) @(negedge clk);
        check_val("t8_nbus", 32'((wr_n - w0) + (rd_n - r0)), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
